morse_symbol_decoder: RTL and testbench
=======================================

Name: morse_symbol_decoder

Overview:
- Parametrised receive-side Morse decoder for the transceiver path.
- Measures high and low run lengths of the sampled serial line in units of UNIT_SAMPLES sample strobes, with rounding tolerance.
- Classifies each run into dot, dash, character break, space, ETX or error, and buffers the symbol codes in a small FIFO with a valid/ready handshake.
- Sits between the line sampler and the character assembler; it generalises fixed-pattern detection to variable unit length and adds buffering and error reporting.

Parameters:
UNIT_SAMPLES, 1, sample strobes per Morse unit (>=1)
CNT_W, 8, width of the per-run sample counter; the counter saturates at 2^CNT_W-1
HIST_W, 8, width of the raw sample history register
FIFO_DEPTH, 4, symbol FIFO entries (power of two, >=2)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
serial_data  input  1  line level, valid when sample=1
sample  input  1  one-cycle sample strobe
sym_code  output  3  head-of-FIFO symbol: 0 dot, 1 dash, 2 char break, 3 space, 4 ETX, 5 error
sym_valid  output  1  FIFO non-empty
sym_ready  input  1  consumer accepts sym_code when sym_valid=1
overflow  output  1  sticky: a symbol was dropped because the FIFO was full
ovf_clear  input  1  clears overflow
receive_history  output  HIST_W  last HIST_W samples, newest in bit 0

Behaviour:
- Reset values:
  - FSM = IDLE; all counters = 0; FIFO empty.
  - sym_valid=0, sym_code=0, overflow=0, receive_history=0.
- All run and FSM activity advances only on cycles with sample=1.
- On each sample, receive_history shifts left and serial_data is inserted at bit 0.
- Run length:
  - L = number of consecutive samples at one level, counted from the first sample of the run; saturates.
  - Units U = floor((L + UNIT_SAMPLES/2) / UNIT_SAMPLES), using integer division.
- FSM states:
  - IDLE: line low, decoder disarmed. Sample of 1 -> MARK with L=1. No gap symbol is ever produced for the leading idle.
  - MARK: sample of 1 -> L+1. Sample of 0 -> classify the mark, then go to GAP with L=1.
    - Mark classification: U=1 dot; U=2 dash; U=0 or U>=3 error.
  - GAP: sample of 0 -> L+1.
    - On the sample where U first reaches 4: push ETX and go to IDLE.
    - Sample of 1 -> classify the gap, then go to MARK with L=1.
    - Gap classification: U=1 no push (intra-character gap); U=2 char break; U=3 space; U=0 error.
- At most one push per sample cycle. A push is written on the sample cycle; sym_valid/sym_code reflect it from the next cycle (one-cycle latency into an empty FIFO).
- FIFO:
  - Pop occurs when sym_valid & sym_ready.
  - Push when full without a same-cycle pop: symbol dropped, overflow set.
  - Push when full with a same-cycle pop: push accepted, no overflow.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow:
  - ovf_clear=1 clears it.
  - A drop in the same cycle as ovf_clear leaves overflow set (set wins).
- sym_code holds the head entry while sym_valid=1 and sym_ready=0. sym_code is don't-care when empty and is driven 0 after reset.
- Reset asserted mid-run or mid-FIFO: everything returns to reset values immediately; partial runs are discarded.

Test Plan:
- UNIT_SAMPLES=1, samples 0,1,0,1,1,0,0,1,0,0,0,1 -> FIFO order: dot, dash, char break, dot, space. sym_valid rises the cycle after the first push.
- UNIT_SAMPLES=4, mark of 5 samples, gap of 3, mark of 9, gap of 10 -> dot, (no gap symbol), dash, space (U=3). Jitter of ±1 sample around each nominal length gives identical codes.
- UNIT_SAMPLES=1, mark 1 then 4 zeros -> dot, then ETX pushed on the 4th zero and FSM=IDLE. Further zeros push nothing; next 1,0 pushes only dot (no gap symbol).
- UNIT_SAMPLES=4, mark of 1 sample -> error (code 5); mark of 12 samples -> error.
- FIFO_DEPTH=4, sym_ready=0, push 5 symbols -> 4 held in order, overflow=1. Then with full FIFO, push and sym_ready=1 in the same cycle -> no new drop, count stays 4. ovf_clear -> overflow=0.
- Assert rst_n low during a mark with 2 entries in the FIFO -> sym_valid=0, overflow=0, receive_history=0 immediately. After release, a leading gap produces no symbol.

Source files
------------

// File: rtl/morse_symbol_decoder.sv
// Receive-side Morse decoder: measures mark/gap run lengths in sample strobes,
// classifies them into symbol codes and buffers the codes in a small FIFO.
module morse_symbol_decoder #(
  parameter int UNIT_SAMPLES = 1,
  parameter int CNT_W        = 8,
  parameter int HIST_W       = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              serial_data,
  input  logic              sample,
  output logic [2:0]        sym_code,
  output logic              sym_valid,
  input  logic              sym_ready,
  output logic              overflow,
  input  logic              ovf_clear,
  output logic [HIST_W-1:0] receive_history
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [2:0] SYM_DOT   = 3'd0;
  localparam logic [2:0] SYM_DASH  = 3'd1;
  localparam logic [2:0] SYM_CHAR  = 3'd2;
  localparam logic [2:0] SYM_SPACE = 3'd3;
  localparam logic [2:0] SYM_ETX   = 3'd4;
  localparam logic [2:0] SYM_ERR   = 3'd5;

  localparam logic [CNT_W:0]   UNIT_V  = (CNT_W+1)'(UNIT_SAMPLES);
  localparam logic [CNT_W:0]   HALF_V  = (CNT_W+1)'(UNIT_SAMPLES / 2);
  localparam logic [CNT_W:0]   USAT_V  = (CNT_W+1)'(4);
  localparam logic [CNT_W-1:0] LEN_ONE = CNT_W'(1);
  localparam logic [PTR_W:0]   DEPTH_V = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, MARK, GAP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  run_len, run_len_nxt;
  logic              push;
  logic [2:0]        push_code;

  logic [2:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic              full, pop, wr_en, drop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Rounded unit count, clamped to 4 since nothing above 4 is distinguished.
  function automatic logic [2:0] units(input logic [CNT_W-1:0] len);
    logic [CNT_W:0] q;
    q = ({1'b0, len} + HALF_V) / UNIT_V;
    return (q > USAT_V) ? 3'd4 : q[2:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      run_len         <= '0;
      receive_history <= '0;
    end else if (sample) begin
      state           <= state_nxt;
      run_len         <= run_len_nxt;
      receive_history <= {receive_history[HIST_W-2:0], serial_data};
    end
  end

  always_comb begin
    state_nxt   = state;
    run_len_nxt = run_len;
    push        = 1'b0;
    push_code   = SYM_DOT;
    if (sample) begin
      case (state)
        IDLE: begin
          if (serial_data) begin
            state_nxt   = MARK;
            run_len_nxt = LEN_ONE;
          end
        end
        MARK: begin
          if (serial_data) begin
            run_len_nxt = sat_inc(run_len);
          end else begin
            push = 1'b1;
            case (units(run_len))
              3'd1:    push_code = SYM_DOT;
              3'd2:    push_code = SYM_DASH;
              default: push_code = SYM_ERR;
            endcase
            state_nxt   = GAP;
            run_len_nxt = LEN_ONE;
          end
        end
        GAP: begin
          if (serial_data) begin
            state_nxt   = MARK;
            run_len_nxt = LEN_ONE;
            case (units(run_len))
              3'd1: push = 1'b0;
              3'd2: begin push = 1'b1; push_code = SYM_CHAR;  end
              3'd3: begin push = 1'b1; push_code = SYM_SPACE; end
              default: begin push = 1'b1; push_code = SYM_ERR; end
            endcase
          end else begin
            run_len_nxt = sat_inc(run_len);
            // A gap of four units ends the message and disarms the decoder.
            if (units(run_len_nxt) == 3'd4) begin
              push        = 1'b1;
              push_code   = SYM_ETX;
              state_nxt   = IDLE;
              run_len_nxt = '0;
            end
          end
        end
        default: begin
          state_nxt   = IDLE;
          run_len_nxt = '0;
        end
      endcase
    end
  end

  // Symbol FIFO
  assign full      = (count == DEPTH_V);
  assign sym_valid = (count != '0);
  assign pop       = sym_valid & sym_ready;
  assign wr_en     = push & (~full | pop);
  assign drop      = push & full & ~pop;
  assign sym_code  = sym_valid ? mem[rd_ptr] : SYM_DOT;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)           overflow <= 1'b1;
      else if (ovf_clear) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_morse_symbol_decoder.sv
// Directed bench for morse_symbol_decoder: one instance at UNIT_SAMPLES=1 and
// one at UNIT_SAMPLES=4, symbols collected by a consumer monitor.
module tb_morse_symbol_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       d1, s1, r1, oc1, valid1, ovf1;
  logic [2:0] code1;
  logic [7:0] hist1;
  logic       d4, s4, r4, oc4, valid4, ovf4;
  logic [2:0] code4;
  logic [7:0] hist4;

  logic [2:0] q1[$];
  logic [2:0] q4[$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  morse_symbol_decoder #(.UNIT_SAMPLES(1), .CNT_W(8), .HIST_W(8), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst_n(rst_n), .serial_data(d1), .sample(s1), .sym_code(code1),
    .sym_valid(valid1), .sym_ready(r1), .overflow(ovf1), .ovf_clear(oc1),
    .receive_history(hist1));

  morse_symbol_decoder #(.UNIT_SAMPLES(4), .CNT_W(8), .HIST_W(8), .FIFO_DEPTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .serial_data(d4), .sample(s4), .sym_code(code4),
    .sym_valid(valid4), .sym_ready(r4), .overflow(ovf4), .ovf_clear(oc4),
    .receive_history(hist4));

  // Consumer: an entry seen with ready high is popped at the next rising edge.
  always begin
    @(negedge clk);
    #1;
    if (valid1 && r1) q1.push_back(code1);
    if (valid4 && r4) q4.push_back(code4);
  end

  task automatic send1(input logic b);
    d1 = b; s1 = 1'b1;
    @(negedge clk);
    s1 = 1'b0;
  endtask

  task automatic run4(input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      d4 = b; s4 = 1'b1;
      @(negedge clk);
      s4 = 1'b0;
    end
  endtask

  task automatic reset_all();
    d1 = 0; s1 = 0; r1 = 0; oc1 = 0;
    d4 = 0; s4 = 0; r4 = 0; oc4 = 0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    q1.delete();
    q4.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_all();
    n_cmp++; if (valid1 !== 1'b0) begin n_bad++; $display("FAIL rst_valid1 got %b want 0", valid1); end
    n_cmp++; if (code1 !== 3'd0) begin n_bad++; $display("FAIL rst_code1 got %0d want 0", code1); end
    n_cmp++; if (ovf1 !== 1'b0) begin n_bad++; $display("FAIL rst_ovf1 got %b want 0", ovf1); end
    n_cmp++; if (hist1 !== 8'h00) begin n_bad++; $display("FAIL rst_hist1 got %h want 00", hist1); end
    n_cmp++; if (valid4 !== 1'b0 || hist4 !== 8'h00 || ovf4 !== 1'b0) begin
      n_bad++; $display("FAIL rst_u4 got v=%b h=%h o=%b want 0/00/0", valid4, hist4, ovf4);
    end
  endtask

  task automatic test_basic_unit1();
    logic [2:0] exp [5] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd3};
    reset_all();
    r1 = 1'b1;
    send1(0); send1(1);
    n_cmp++; if (valid1 !== 1'b0) begin n_bad++; $display("FAIL basic_pre_valid got %b want 0", valid1); end
    send1(0);
    n_cmp++; if (valid1 !== 1'b1 || code1 !== 3'd0) begin
      n_bad++; $display("FAIL basic_first_push got v=%b c=%0d want 1/0", valid1, code1);
    end
    send1(1); send1(1); send1(0); send1(0); send1(1); send1(0); send1(0); send1(0); send1(1);
    n_cmp++; if (hist1 !== 8'h91) begin n_bad++; $display("FAIL basic_hist got %h want 91", hist1); end
    repeat (4) @(negedge clk);
    n_cmp++; if (q1.size() != 5) begin n_bad++; $display("FAIL basic_count got %0d want 5", q1.size()); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (q1.size() <= i || q1[i] !== exp[i]) begin
        n_bad++; $display("FAIL basic_sym%0d got %0d want %0d", i, (q1.size() > i) ? q1[i] : 3'd7, exp[i]);
      end
    end
  endtask

  task automatic test_unit4_nominal();
    logic [2:0] exp [3] = '{3'd0, 3'd1, 3'd3};
    reset_all();
    r4 = 1'b1;
    run4(1, 5); run4(0, 3); run4(1, 9); run4(0, 10); run4(1, 1);
    repeat (4) @(negedge clk);
    n_cmp++; if (q4.size() != 3) begin n_bad++; $display("FAIL u4nom_count got %0d want 3", q4.size()); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (q4.size() <= i || q4[i] !== exp[i]) begin
        n_bad++; $display("FAIL u4nom_sym%0d got %0d want %0d", i, (q4.size() > i) ? q4[i] : 3'd7, exp[i]);
      end
    end
  endtask

  task automatic test_unit4_jitter();
    int marks [5] = '{3, 7, 9, 4, 5};
    int gaps  [5] = '{5, 7, 11, 13, 3};
    logic [2:0] exp [8] = '{3'd0, 3'd1, 3'd2, 3'd1, 3'd3, 3'd0, 3'd3, 3'd0};
    reset_all();
    r4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run4(1, marks[i]);
      run4(0, gaps[i]);
    end
    run4(1, 1);
    repeat (4) @(negedge clk);
    n_cmp++; if (q4.size() != 8) begin n_bad++; $display("FAIL jitter_count got %0d want 8", q4.size()); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (q4.size() <= i || q4[i] !== exp[i]) begin
        n_bad++; $display("FAIL jitter_sym%0d got %0d want %0d", i, (q4.size() > i) ? q4[i] : 3'd7, exp[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [2:0] exp [4] = '{3'd5, 3'd5, 3'd5, 3'd0};
    reset_all();
    r4 = 1'b1;
    run4(1, 1); run4(0, 4); run4(1, 12); run4(0, 1); run4(1, 4); run4(0, 4); run4(1, 1);
    repeat (4) @(negedge clk);
    n_cmp++; if (q4.size() != 4) begin n_bad++; $display("FAIL err_count got %0d want 4", q4.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (q4.size() <= i || q4[i] !== exp[i]) begin
        n_bad++; $display("FAIL err_sym%0d got %0d want %0d", i, (q4.size() > i) ? q4[i] : 3'd7, exp[i]);
      end
    end
  endtask

  task automatic test_etx();
    logic [2:0] exp [3] = '{3'd0, 3'd4, 3'd0};
    reset_all();
    r1 = 1'b1;
    send1(1); send1(0); send1(0); send1(0);
    n_cmp++; if (valid1 !== 1'b0 || q1.size() != 1) begin
      n_bad++; $display("FAIL etx_early got v=%b n=%0d want 0/1", valid1, q1.size());
    end
    send1(0);
    n_cmp++; if (valid1 !== 1'b1 || code1 !== 3'd4) begin
      n_bad++; $display("FAIL etx_push got v=%b c=%0d want 1/4", valid1, code1);
    end
    n_cmp++; if (hist1 !== 8'h10) begin n_bad++; $display("FAIL etx_hist got %h want 10", hist1); end
    send1(0); send1(0); send1(0);
    send1(1); send1(0);
    repeat (4) @(negedge clk);
    n_cmp++; if (hist1 !== 8'h02) begin n_bad++; $display("FAIL etx_hist2 got %h want 02", hist1); end
    n_cmp++; if (q1.size() != 3) begin n_bad++; $display("FAIL etx_count got %0d want 3", q1.size()); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (q1.size() <= i || q1[i] !== exp[i]) begin
        n_bad++; $display("FAIL etx_sym%0d got %0d want %0d", i, (q1.size() > i) ? q1[i] : 3'd7, exp[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [2:0] exp [5] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd0};
    reset_all();
    send1(1); send1(0);
    send1(1); send1(1); send1(0);
    send1(0); send1(1);
    send1(0);
    send1(0); send1(0);
    n_cmp++; if (ovf1 !== 1'b0) begin n_bad++; $display("FAIL ovf_premature got %b want 0", ovf1); end
    oc1 = 1'b1;
    send1(1);
    oc1 = 1'b0;
    n_cmp++; if (ovf1 !== 1'b1) begin n_bad++; $display("FAIL ovf_set_wins got %b want 1", ovf1); end
    repeat (2) @(negedge clk);
    n_cmp++; if (valid1 !== 1'b1 || code1 !== 3'd0) begin
      n_bad++; $display("FAIL ovf_head_hold got v=%b c=%0d want 1/0", valid1, code1);
    end
    oc1 = 1'b1;
    @(negedge clk);
    oc1 = 1'b0;
    n_cmp++; if (ovf1 !== 1'b0) begin n_bad++; $display("FAIL ovf_clear got %b want 0", ovf1); end
    r1 = 1'b1;
    send1(0);
    r1 = 1'b0;
    n_cmp++; if (ovf1 !== 1'b0) begin n_bad++; $display("FAIL ovf_push_pop got %b want 0", ovf1); end
    n_cmp++; if (valid1 !== 1'b1 || code1 !== 3'd1) begin
      n_bad++; $display("FAIL ovf_new_head got v=%b c=%0d want 1/1", valid1, code1);
    end
    r1 = 1'b1;
    repeat (8) @(negedge clk);
    r1 = 1'b0;
    n_cmp++; if (q1.size() != 5) begin n_bad++; $display("FAIL ovf_count got %0d want 5", q1.size()); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (q1.size() <= i || q1[i] !== exp[i]) begin
        n_bad++; $display("FAIL ovf_sym%0d got %0d want %0d", i, (q1.size() > i) ? q1[i] : 3'd7, exp[i]);
      end
    end
    n_cmp++; if (valid1 !== 1'b0) begin n_bad++; $display("FAIL ovf_empty got %b want 0", valid1); end
  endtask

  task automatic test_mid_reset();
    reset_all();
    send1(1); send1(0);
    send1(1); send1(1); send1(0);
    send1(1); send1(1);
    n_cmp++; if (valid1 !== 1'b1 || hist1 === 8'h00) begin
      n_bad++; $display("FAIL mrst_setup got v=%b h=%h want 1/nonzero", valid1, hist1);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (valid1 !== 1'b0 || ovf1 !== 1'b0 || hist1 !== 8'h00 || code1 !== 3'd0) begin
      n_bad++; $display("FAIL mrst_async got v=%b o=%b h=%h c=%0d want 0/0/00/0", valid1, ovf1, hist1, code1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) send1(0);
    n_cmp++; if (valid1 !== 1'b0) begin n_bad++; $display("FAIL mrst_lead_gap got %b want 0", valid1); end
    send1(1); send1(1); send1(0);
    n_cmp++; if (valid1 !== 1'b1 || code1 !== 3'd1) begin
      n_bad++; $display("FAIL mrst_after got v=%b c=%0d want 1/1", valid1, code1);
    end
  endtask

  initial begin
    test_reset();
    test_basic_unit1();
    test_unit4_nominal();
    test_unit4_jitter();
    test_errors();
    test_etx();
    test_overflow();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
